// File: rtl/snoop_responder_pkg.sv
// Shared definitions for the snoop responder and the bus controller:
// address width, MSI state encodings and the responder FSM state type.
package common;

    localparam int unsigned ADDR_W = 13;

    localparam logic [1:0] BLOCK_STATE_MODIFIED = 2'b10;
    localparam logic [1:0] BLOCK_STATE_SHARED   = 2'b01;
    localparam logic [1:0] BLOCK_STATE_INVALID  = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_SUPPLY1 = 2'd2,
        S_SUPPLY2 = 2'd3
    } snoop_state_t;

endpackage

// File: rtl/snoop_responder_if.sv
// Bundle of bus-side and local-cache-side signals of the snoop responder.
// The slave modport is the responder; the master modport is its environment.
interface snoop_responder_if #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned DATA_W  = 16
);
    logic                      search;
    logic                      snoop_inv;
    logic [common::ADDR_W-1:0] boci;
    logic                      search_found;
    logic [1:0]                block_state;
    logic                      upd_we;
    logic [common::ADDR_W-1:0] upd_addr;
    logic [1:0]                upd_state;
    logic                      data_rd_req;
    logic [INDEX_W-1:0]        data_rd_idx;
    logic                      data_rd_vld;
    logic [DATA_W-1:0]         data_rd;
    logic [DATA_W-1:0]         fwd_data;
    logic                      fwd_vld;
    logic                      st_wr;
    logic [INDEX_W-1:0]        st_idx;
    logic [1:0]                st_new;
    logic                      busy;
    logic                      proto_err;

    modport slave (
        input  search, snoop_inv, boci, upd_we, upd_addr, upd_state, data_rd_vld, data_rd,
        output search_found, block_state, data_rd_req, data_rd_idx, fwd_data, fwd_vld,
        output st_wr, st_idx, st_new, busy, proto_err
    );

    modport master (
        output search, snoop_inv, boci, upd_we, upd_addr, upd_state, data_rd_vld, data_rd,
        input  search_found, block_state, data_rd_req, data_rd_idx, fwd_data, fwd_vld,
        input  st_wr, st_idx, st_new, busy, proto_err
    );

endinterface

// File: rtl/snoop_responder_tag_array.sv
// Duplicate tag/state array mirroring the local d-cache, with combinational
// lookup and the merge of invalidate, local update and M->S downgrade writes.
module snoop_tag_array
    import common::*;
#(
    parameter int unsigned INDEX_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [1:0]        lookup_state,
    input  logic              inv_req,
    input  logic              upd_we,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [1:0]        upd_state,
    input  logic              dng_we,
    input  logic [ADDR_W-1:0] dng_addr
);
    localparam int unsigned TAG_W     = ADDR_W - INDEX_W;
    localparam int unsigned NUM_LINES = 2 ** INDEX_W;

    logic [TAG_W-1:0] tag_q [NUM_LINES];
    logic [TAG_W-1:0] tag_d [NUM_LINES];
    logic [1:0]       st_q  [NUM_LINES];
    logic [1:0]       st_d  [NUM_LINES];

    logic [INDEX_W-1:0] lk_idx, upd_idx, dng_idx;
    logic [TAG_W-1:0]   lk_tag, upd_tag, dng_tag;
    logic               inv_hit;

    assign lk_idx  = lookup_addr[INDEX_W-1:0];
    assign lk_tag  = lookup_addr[ADDR_W-1:INDEX_W];
    assign upd_idx = upd_addr[INDEX_W-1:0];
    assign upd_tag = upd_addr[ADDR_W-1:INDEX_W];
    assign dng_idx = dng_addr[INDEX_W-1:0];
    assign dng_tag = dng_addr[ADDR_W-1:INDEX_W];

    assign lookup_hit   = (st_q[lk_idx] != BLOCK_STATE_INVALID) && (tag_q[lk_idx] == lk_tag);
    assign lookup_state = lookup_hit ? st_q[lk_idx] : BLOCK_STATE_INVALID;
    assign inv_hit      = inv_req && lookup_hit;

    // Priority per line: invalidate > local update > downgrade, except that a
    // local update carrying a different tag replaces the line being invalidated.
    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            tag_d[i] = tag_q[i];
            st_d[i]  = st_q[i];
            if (dng_we && dng_idx == INDEX_W'(i)) begin
                tag_d[i] = dng_tag;
                st_d[i]  = BLOCK_STATE_SHARED;
            end
            if (upd_we && upd_idx == INDEX_W'(i)) begin
                tag_d[i] = upd_tag;
                st_d[i]  = upd_state;
            end
            if (inv_hit && lk_idx == INDEX_W'(i) &&
                !(upd_we && upd_idx == lk_idx && upd_tag != lk_tag)) begin
                st_d[i] = BLOCK_STATE_INVALID;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i] <= '0;
                st_q[i]  <= BLOCK_STATE_INVALID;
            end
        end else begin
            tag_q <= tag_d;
            st_q  <= st_d;
        end
    end

endmodule

// File: rtl/snoop_responder.sv
// Per-CPU snoop-side responder: answers bus searches, fetches and forwards
// hit data, and mirrors invalidates/downgrades. Option: SNOOP_STATS_EN adds counters.
module snoop_responder
    import common::*;
#(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    snoop_responder_if.slave   bus
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0]        stat_hits,
    output logic [15:0]        stat_invs
`endif
);
    snoop_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic               dng_pend_q;
    logic               found_q;
    logic [1:0]         bstate_q;
    logic [DATA_W-1:0]  fwd_data_q;
    logic               st_wr_q;
    logic [INDEX_W-1:0] st_idx_q;
    logic [1:0]         st_new_q;
    logic               perr_q;

    logic               lookup_hit;
    logic [1:0]         lookup_state;
    logic               accept, inv_hit, dng_we;

    snoop_tag_array #(
        .INDEX_W (INDEX_W)
    ) u_tag_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_addr  (bus.boci),
        .lookup_hit   (lookup_hit),
        .lookup_state (lookup_state),
        .inv_req      (bus.snoop_inv),
        .upd_we       (bus.upd_we),
        .upd_addr     (bus.upd_addr),
        .upd_state    (bus.upd_state),
        .dng_we       (dng_we),
        .dng_addr     (addr_q)
    );

    assign accept  = bus.search && (state_q == S_IDLE);
    assign inv_hit = bus.snoop_inv && lookup_hit;
    // An invalidate in the same cycle owns the single st_wr slot; the downgrade is lost.
    assign dng_we  = (state_q == S_SUPPLY2) && dng_pend_q && !inv_hit;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (bus.search && lookup_hit) state_d = S_FETCH;
            S_FETCH:   if (bus.data_rd_vld) state_d = S_SUPPLY1;
            S_SUPPLY1: state_d = S_SUPPLY2;
            S_SUPPLY2: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            dng_pend_q <= 1'b0;
            found_q    <= 1'b0;
            bstate_q   <= BLOCK_STATE_INVALID;
            fwd_data_q <= '0;
            st_wr_q    <= 1'b0;
            st_idx_q   <= '0;
            st_new_q   <= BLOCK_STATE_INVALID;
            perr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= bus.boci;
                found_q    <= lookup_hit;
                bstate_q   <= lookup_state;
                dng_pend_q <= lookup_hit && (lookup_state == BLOCK_STATE_MODIFIED) && !inv_hit;
            end else if (state_q == S_SUPPLY2 || (inv_hit && bus.boci == addr_q)) begin
                dng_pend_q <= 1'b0;
            end
            if (state_q == S_FETCH && bus.data_rd_vld) begin
                fwd_data_q <= bus.data_rd;
            end
            st_wr_q <= inv_hit || dng_we;
            if (inv_hit) begin
                st_idx_q <= bus.boci[INDEX_W-1:0];
                st_new_q <= BLOCK_STATE_INVALID;
            end else if (dng_we) begin
                st_idx_q <= addr_q[INDEX_W-1:0];
                st_new_q <= BLOCK_STATE_SHARED;
            end
            if (bus.search && state_q != S_IDLE) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign bus.search_found = found_q;
    assign bus.block_state  = bstate_q;
    assign bus.data_rd_req  = (state_q == S_FETCH);
    assign bus.data_rd_idx  = addr_q[INDEX_W-1:0];
    assign bus.fwd_data     = fwd_data_q;
    assign bus.fwd_vld      = (state_q == S_SUPPLY1) || (state_q == S_SUPPLY2);
    assign bus.st_wr        = st_wr_q;
    assign bus.st_idx       = st_idx_q;
    assign bus.st_new       = st_new_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.proto_err    = perr_q;

`ifdef SNOOP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits <= '0;
            stat_invs <= '0;
        end else begin
            if (accept && lookup_hit && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
            if (inv_hit && stat_invs != 16'hFFFF) stat_invs <= stat_invs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: a transaction-level model predicts
// responses into queues and an independent monitor checks the DUT outputs.
module tb_snoop_responder;
    import common::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snoop_responder_if #(.INDEX_W(6), .DATA_W(16)) bus ();
`ifdef SNOOP_STATS_EN
    logic [15:0] stat_hits, stat_invs;
    snoop_responder #(.INDEX_W(6), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stat_hits(stat_hits), .stat_invs(stat_invs));
`else
    snoop_responder #(.INDEX_W(6), .DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    typedef struct { int due; logic found; logic [1:0] st; logic perr; } srch_t;
    typedef struct { int due; logic [5:0] idx; } fetch_t;
    typedef struct { int due; logic [15:0] data; } fwd_t;
    typedef struct { int due; logic [5:0] idx; logic [1:0] st; } stw_t;

    srch_t  q_search[$];
    fetch_t q_fetch[$];
    fwd_t   q_fwd[$];
    stw_t   q_st[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: mirror contents plus the cycle numbers of the open transaction
    logic [6:0]  m_tag [64];
    logic [1:0]  m_st  [64];
    int          busy_until, vld_cyc, dng_cyc, fixed_lat;
    bit          pend;
    logic [12:0] pend_addr;
    logic        last_found, exp_perr;
    logic [1:0]  last_st;
    logic [15:0] fetch_data, next_data;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_tag[i] = '0;
            m_st[i]  = 2'b00;
        end
        busy_until = -10; vld_cyc = -10; dng_cyc = -10;
        pend = 0; pend_addr = '0;
        last_found = 0; last_st = 2'b00; exp_perr = 0;
        q_search.delete(); q_fetch.delete(); q_fwd.delete(); q_st.delete();
    endtask

    task automatic idle_inputs();
        bus.search = 0; bus.snoop_inv = 0; bus.boci = '0;
        bus.upd_we = 0; bus.upd_addr = '0; bus.upd_state = 2'b00;
        bus.data_rd_vld = 0; bus.data_rd = '0;
    endtask

    task automatic chk_reset_vals();
        chk("rst search_found", bus.search_found, 0);
        chk("rst block_state", bus.block_state, 0);
        chk("rst data_rd_req", bus.data_rd_req, 0);
        chk("rst data_rd_idx", bus.data_rd_idx, 0);
        chk("rst fwd_data", bus.fwd_data, 0);
        chk("rst fwd_vld", bus.fwd_vld, 0);
        chk("rst st_wr", bus.st_wr, 0);
        chk("rst st_idx", bus.st_idx, 0);
        chk("rst st_new", bus.st_new, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst proto_err", bus.proto_err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        #1;
        chk_reset_vals();
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    // Drive one cycle of stimulus and predict its consequences.
    task automatic step(input bit s, input bit inv, input logic [12:0] a,
                        input bit uw, input logic [12:0] ua, input logic [1:0] us);
        int c, lat;
        logic [5:0] idx;
        logic [6:0] tag;
        logic [1:0] cur;
        bit hit, inv_hit, dng_now;
        @(negedge clk);
        c = cyc;
        if (c == vld_cyc) begin
            bus.data_rd_vld = 1;
            bus.data_rd = fetch_data;
            q_fwd.push_back('{c + 1, fetch_data});
        end else begin
            bus.data_rd_vld = 0;
            bus.data_rd = 16'($urandom);
        end
        idx = a[5:0];
        tag = a[12:6];
        cur = m_st[idx];
        hit = (cur != 2'b00) && (m_tag[idx] == tag);
        inv_hit = inv && hit;
        if (s) begin
            if (c <= busy_until) begin
                exp_perr = 1;
            end else begin
                last_found = hit;
                last_st = hit ? cur : 2'b00;
                if (hit) begin
                    lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
                    vld_cyc = c + lat;
                    busy_until = c + lat + 2;
                    dng_cyc = c + lat + 2;
                    q_fetch.push_back('{c + 1, idx});
                    fetch_data = next_data;
                    next_data = 16'($urandom);
                    pend = (cur == 2'b10) && !inv_hit;
                    pend_addr = a;
                end
            end
            q_search.push_back('{c + 1, last_found, last_st, exp_perr});
        end
        if (inv_hit) begin
            q_st.push_back('{c + 1, idx, 2'b00});
            if (pend && pend_addr == a) pend = 0;
        end
        dng_now = 0;
        if (pend && c == dng_cyc) begin
            pend = 0;
            if (!inv_hit) begin
                dng_now = 1;
                q_st.push_back('{c + 1, pend_addr[5:0], 2'b01});
            end
        end
        if (dng_now) begin
            m_tag[pend_addr[5:0]] = pend_addr[12:6];
            m_st[pend_addr[5:0]] = 2'b01;
        end
        if (uw) begin
            m_tag[ua[5:0]] = ua[12:6];
            m_st[ua[5:0]] = us;
        end
        if (inv_hit && !(uw && ua[5:0] == idx && ua[12:6] != tag)) m_st[idx] = 2'b00;
        bus.search = s; bus.snoop_inv = inv; bus.boci = a;
        bus.upd_we = uw; bus.upd_addr = ua; bus.upd_state = us;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 2'b00);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    initial begin
        logic prev_req, prev_fwd;
        int run;
        logic [15:0] fwd_exp;
        srch_t se;
        fetch_t fe;
        fwd_t we;
        stw_t te;
        prev_req = 0; prev_fwd = 0; run = 0; fwd_exp = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_req = 0; prev_fwd = 0; run = 0;
                continue;
            end
            while (q_search.size() > 0 && q_search[0].due <= cyc) begin
                se = q_search.pop_front();
                chk("search_found", bus.search_found, se.found);
                chk("block_state", bus.block_state, se.st);
                chk("proto_err", bus.proto_err, se.perr);
            end
            if (bus.data_rd_req && !prev_req) begin
                if (q_fetch.size() == 0) begin
                    chk("spurious data_rd_req", bus.data_rd_req, 0);
                end else begin
                    fe = q_fetch.pop_front();
                    chk("data_rd_req cycle", cyc, fe.due);
                    chk("data_rd_idx", bus.data_rd_idx, fe.idx);
                end
            end else if (q_fetch.size() > 0 && q_fetch[0].due < cyc) begin
                void'(q_fetch.pop_front());
                chk("missing data_rd_req", bus.data_rd_req, 1);
            end
            if (bus.fwd_vld && !prev_fwd) begin
                run = 1;
                if (q_fwd.size() == 0) begin
                    chk("spurious fwd_vld", bus.fwd_vld, 0);
                end else begin
                    we = q_fwd.pop_front();
                    fwd_exp = we.data;
                    chk("fwd_vld cycle", cyc, we.due);
                    chk("fwd_data", bus.fwd_data, we.data);
                end
            end else if (bus.fwd_vld) begin
                run++;
                chk("fwd_data held", bus.fwd_data, fwd_exp);
            end else if (q_fwd.size() > 0 && q_fwd[0].due < cyc) begin
                void'(q_fwd.pop_front());
                chk("missing fwd_vld", bus.fwd_vld, 1);
            end
            if (!bus.fwd_vld && prev_fwd) chk("fwd_vld length", run, 2);
            if (bus.st_wr) begin
                if (q_st.size() == 0) begin
                    chk("spurious st_wr", bus.st_wr, 0);
                end else begin
                    te = q_st.pop_front();
                    chk("st_wr cycle", cyc, te.due);
                    chk("st_idx", bus.st_idx, te.idx);
                    chk("st_new", bus.st_new, te.st);
                end
            end else if (q_st.size() > 0 && q_st[0].due < cyc) begin
                void'(q_st.pop_front());
                chk("missing st_wr", bus.st_wr, 1);
            end
            prev_req = bus.data_rd_req;
            prev_fwd = bus.fwd_vld;
        end
    end

    initial begin
        logic [12:0] a, ua;
        bit s, inv, uw;
        logic [1:0] us;
        idle_inputs();
        model_reset();
        fixed_lat = 2;
        next_data = 16'hBEEF;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst_n = 1;

        // Shared line: search hit, fetch and forward
        step(0, 0, '0, 1, 13'h0A5, 2'b01);
        step(1, 0, 13'h0A5, 0, '0, 2'b00);
        idle(6);
        // Modified line: supply then downgrade to S, re-search sees S
        step(0, 0, '0, 1, 13'h0A5, 2'b10);
        step(1, 0, 13'h0A5, 0, '0, 2'b00);
        idle(6);
        step(1, 0, 13'h0A5, 0, '0, 2'b00);
        idle(6);
        // Same index, different tag: miss
        step(1, 0, 13'h1A5, 0, '0, 2'b00);
        idle(2);
        // Invalidate during SUPPLY1 of an M line: forward completes, no downgrade
        fixed_lat = 1;
        step(0, 0, '0, 1, 13'h0A5, 2'b10);
        step(1, 0, 13'h0A5, 0, '0, 2'b00);
        step(0, 0, '0, 0, '0, 2'b00);
        step(0, 1, 13'h0A5, 0, '0, 2'b00);
        idle(5);
        // Local update and invalidate on the same line in one cycle
        step(0, 0, '0, 1, 13'h0A5, 2'b01);
        step(0, 1, 13'h0A5, 1, 13'h0A5, 2'b10);
        step(1, 0, 13'h0A5, 0, '0, 2'b00);
        idle(2);
        // Search while fetching sets proto_err
        fixed_lat = 4;
        step(0, 0, '0, 1, 13'h0A5, 2'b01);
        step(1, 0, 13'h0A5, 0, '0, 2'b00);
        step(1, 0, 13'h0A5, 0, '0, 2'b00);
        idle(8);
        chk("proto_err sticky", bus.proto_err, 1);
        // Reset during FETCH
        step(1, 0, 13'h0A5, 0, '0, 2'b00);
        step(0, 0, '0, 0, '0, 2'b00);
        chk("busy in fetch", bus.busy, 1);
        do_reset();
        step(1, 0, 13'h0A5, 0, '0, 2'b00);
        idle(3);

        fixed_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            s   = ($urandom % 4) == 0;
            inv = ($urandom % 8) == 0;
            a   = {7'($urandom % 3), 6'($urandom % 4)};
            uw  = ($urandom % 3) == 0;
            ua  = {7'($urandom % 3), 6'($urandom % 4)};
            us  = 2'($urandom % 3);
            if (pend && ua[5:0] == pend_addr[5:0]) uw = 0;
            step(s, inv, a, uw, ua, us);
        end
        idle(12);
        chk("search queue drained", q_search.size(), 0);
        chk("fetch queue drained", q_fetch.size(), 0);
        chk("fwd queue drained", q_fwd.size(), 0);
        chk("st_wr queue drained", q_st.size(), 0);
        chk("final proto_err", bus.proto_err, exp_perr);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
